// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: walks each instruction through IF/ID/EX/MEM/WB
// and decodes the datapath selects and write enables from the current state.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               MIO_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtZero,
  output logic [2:0]         ALU_Control,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [STATE_W-1:0] state_out
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
    S_LWB = 4'd4,  S_MW  = 4'd5,  S_RE  = 4'd6,  S_RWB = 4'd7,
    S_BR  = 4'd8,  S_J   = 4'd9,  S_IE  = 4'd10, S_IWB = 4'd11,
    S_LUI = 4'd12, S_JAL = 4'd13, S_JR  = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_r;
  state_e id_next_s;
  logic   unused_zero_s;

  // Branch resolution lives in the datapath, so the zero flag is not decoded here.
  assign unused_zero_s = zero;
  assign state_out     = STATE_W'(state_r);

  function automatic logic rtype_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010: rtype_legal = 1'b1;
      default:                         rtype_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b100110: rtype_alu = ALU_XOR;
      6'b100111: rtype_alu = ALU_NOR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

  // Instruction decode: where ID goes next.
  always_comb begin
    id_next_s = S_IF;
    case (opcode)
      OP_LW, OP_SW: id_next_s = S_MA;
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          id_next_s = S_JR;
        end else if (rtype_legal(funct)) begin
          id_next_s = S_RE;
        end else begin
          id_next_s = S_IF;
        end
      end
      OP_BEQ, OP_BNE:                     id_next_s = S_BR;
      OP_J:                               id_next_s = S_J;
      OP_JAL:                             id_next_s = S_JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  id_next_s = S_IE;
      OP_LUI:                             id_next_s = S_LUI;
      default:                            id_next_s = S_IF;
    endcase
  end

  // State register; memory states hold until the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IF;
    end else begin
      case (state_r)
        S_IF: state_r <= MIO_ready ? S_ID : S_IF;
        S_ID: state_r <= id_next_s;
        S_MA: begin
          if (opcode == OP_LW) begin
            state_r <= S_MR;
          end else if (opcode == OP_SW) begin
            state_r <= S_MW;
          end else begin
            state_r <= S_IF;
          end
        end
        S_MR:    state_r <= MIO_ready ? S_LWB : S_MR;
        S_MW:    state_r <= MIO_ready ? S_IF : S_MW;
        S_RE:    state_r <= S_RWB;
        S_IE:    state_r <= S_IWB;
        default: state_r <= S_IF;
      endcase
    end
  end

  // Control decode from the current state plus the instruction fields.
  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    CPU_MIO     = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtZero     = 1'b0;
    ALU_Control = ALU_ADD;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    case (state_r)
      S_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID: ALUSrcB = 2'b11;
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MR: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        IorD    = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MW: begin
        MemWrite = 1'b1;
        CPU_MIO  = 1'b1;
        IorD     = 1'b1;
      end
      S_RE: begin
        ALUSrcA     = 1'b1;
        ALU_Control = rtype_alu(funct);
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Branch      = (opcode == OP_BEQ);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      // Write-back keeps the ALU inputs steady so the result stays valid.
      S_IE, S_IWB: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ExtZero     = (opcode == OP_ANDI) || (opcode == OP_ORI);
        ALU_Control = imm_alu(opcode);
        RegWrite    = (state_r == S_IWB);
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JR: begin
        ALUSrcA  = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      default: begin
        MemRead = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed and random instruction streams
// compared cycle by cycle against a per-instruction state-sequence model.
module tb_mc_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        MIO_ready;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic        ALUSrcA, ExtZero, PCWrite, PCWriteCond, Branch;
  logic [2:0]  ALU_Control;
  logic [3:0]  state_out;
  logic [21:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtZero(ExtZero), .ALU_Control(ALU_Control), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .state_out(state_out)
  );

  assign dut_vec = {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, RegDst,
                    MemtoReg, ALUSrcA, ALUSrcB, ExtZero, ALU_Control, PCSource,
                    PCWrite, PCWriteCond, Branch};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control word for a given state, written straight from the state table.
  function automatic logic [21:0] exp_vec(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic rdy);
    logic mr, mw, cm, iord, irw, rw, asa, ez, pcw, pcc, br;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] alu;
    {mr, mw, cm, iord, irw, rw, asa, ez, pcw, pcc, br} = 11'b0;
    {rd, m2r, asb, pcs} = 8'b0;
    alu = 3'b010;
    case (st)
      0:  begin mr = 1'b1; cm = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; cm = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 2'b01; end
      5:  begin mw = 1'b1; cm = 1'b1; iord = 1'b1; end
      6:  begin
        asa = 1'b1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b100110: alu = 3'b011;
          6'b100111: alu = 3'b100;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      7:  begin rw = 1'b1; rd = 2'b01; end
      8:  begin asa = 1'b1; alu = 3'b110; pcc = 1'b1; pcs = 2'b01; br = (op == 6'b000100); end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10, 11: begin
        asa = 1'b1; asb = 2'b10;
        rw  = (st == 11);
        if (op == 6'b001100) begin ez = 1'b1; alu = 3'b000; end
        else if (op == 6'b001101) begin ez = 1'b1; alu = 3'b001; end
        else if (op == 6'b001010) alu = 3'b111;
        else alu = 3'b010;
      end
      12: begin rw = 1'b1; m2r = 2'b10; end
      13: begin rw = 1'b1; rd = 2'b10; m2r = 2'b11; pcw = 1'b1; pcs = 2'b10; end
      14: begin asa = 1'b1; pcw = 1'b1; pcs = 2'b11; end
      default: mr = 1'b0;
    endcase
    return {mr, mw, cm, iord, irw, rw, rd, m2r, asa, asb, ez, alu, pcs, pcw, pcc, br};
  endfunction

  // States visited after ID for each instruction class.
  function automatic void tail_states(input logic [5:0] op, input logic [5:0] fn,
                                      output int t[$]);
    t = {};
    case (op)
      6'b100011: t = {2, 3, 4};
      6'b101011: t = {2, 5};
      6'b000000: begin
        if (fn == 6'b001000) t = {14};
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010}) t = {6, 7};
        else t = {};
      end
      6'b000100, 6'b000101: t = {8};
      6'b000010: t = {9};
      6'b000011: t = {13};
      6'b001000, 6'b001100, 6'b001101, 6'b001010: t = {10, 11};
      6'b001111: t = {12};
      default: t = {};
    endcase
  endfunction

  // Drive one cycle's ready, then compare state and controls at the falling edge.
  task automatic step(input logic rdy, input int exp_st);
    MIO_ready = rdy;
    zero = 1'($urandom);
    @(negedge clk);
    check($sformatf("state op=%b fn=%b", opcode, funct), 32'(state_out), 32'(exp_st));
    check($sformatf("ctrl st=%0d op=%b fn=%b rdy=%b", exp_st, opcode, funct, rdy),
          32'(dut_vec), 32'(exp_vec(exp_st, opcode, funct, rdy)));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wait_if, input int wait_mem);
    int t[$];
    opcode = op;
    funct  = fn;
    tail_states(op, fn, t);
    for (int i = 0; i < wait_if; i++) step(1'b0, 0);
    step(1'b1, 0);
    step(1'($urandom), 1);
    foreach (t[k]) begin
      if (t[k] == 3 || t[k] == 5) begin
        for (int w = 0; w < wait_mem; w++) step(1'b0, t[k]);
        step(1'b1, t[k]);
      end else begin
        step(1'($urandom), t[k]);
      end
    end
  endtask

  logic [5:0] ops [14] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001101,
                           6'b001010, 6'b001111, 6'b111111, 6'b000110};
  logic [5:0] fns [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                           6'b100111, 6'b101010, 6'b001000, 6'b000001};

  initial begin
    rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; MIO_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst state", 32'(state_out), 32'd0);
    check("rst ctrl rdy0", 32'(dut_vec), 32'(exp_vec(0, opcode, funct, 1'b0)));
    MIO_ready = 1'b1;
    #1;
    check("rst ctrl rdy1", 32'(dut_vec), 32'(exp_vec(0, opcode, funct, 1'b1)));
    MIO_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(6'b100011, 6'b000000, 3, 2);   // lw with fetch and memory stalls
    run_instr(6'b000000, 6'b100010, 0, 0);   // sub
    run_instr(6'b000011, 6'b000000, 0, 0);   // jal
    run_instr(6'b000100, 6'b000000, 0, 0);   // beq
    run_instr(6'b000101, 6'b000000, 0, 0);   // bne
    run_instr(6'b001100, 6'b000000, 0, 0);   // andi
    run_instr(6'b111111, 6'b000000, 0, 0);   // illegal opcode
    run_instr(6'b000000, 6'b000001, 0, 0);   // illegal funct
    run_instr(6'b000000, 6'b001000, 1, 0);   // jr
    run_instr(6'b001111, 6'b000000, 0, 0);   // lui
    run_instr(6'b101011, 6'b000000, 0, 3);   // sw

    for (int n = 0; n < 250; n++) begin
      run_instr(ops[$urandom_range(0, 13)],
                ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 8)] : 6'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset asserted while a store is stalled in MW.
    opcode = 6'b101011;
    funct  = 6'b000000;
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b0, 5);
    check("pre-rst MemWrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst state", 32'(state_out), 32'd0);
    check("async rst MemWrite", 32'(MemWrite), 32'd0);
    check("async rst ctrl", 32'(dut_vec), 32'(exp_vec(0, opcode, funct, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(6'b001000, 6'b000000, 0, 0);   // addi after reset
    run_instr(6'b100011, 6'b000000, 0, 0);   // lw after reset
    step(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit. Sequences each instruction through IF/ID/EX/MEM/WB states.
- Drives every datapath select and write enable, including the 2-bit RegDst select that the 5-bit 4:1 write-address mux consumes (rt/rd/$31).
- Sits between the instruction register (opcode/funct) plus the memory ready handshake and the datapath muxes, registers and memory interface.

Parameters:
- STATE_W, 4, state register width. 15 states are used, encodings 0–14.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from the end of IF until the next IF.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag; not used for any decode (branch resolution is in the datapath).
- MIO_ready  in  1  memory ready; 1 means the current access completes this cycle.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- CPU_MIO  out  1  memory access request.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  write-address select: 00 = rt, 01 = rd, 10 = 5'd31, 11 unused.
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = {imm,16'h0}, 11 = PC.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- ExtZero  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- ALU_Control  out  3  and 000, or 001, add 010, xor 011, nor 100, sub 110, slt 111.
- PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  conditional PC write.
- Branch  out  1  branch polarity: 1 = beq (taken on zero), 0 = bne.
- state_out  out  4  current state, for debug display.

Behaviour:
- State register is asynchronously cleared to IF (0) while rst_n = 0. Reset taking effect mid-instruction abandons that instruction; no other state survives.
- Outputs are combinational from the state register plus opcode/funct. Every output not listed for a state is 0, and ALU_Control defaults to 010.
- Reset values follow IF decode: MemRead = 1, CPU_MIO = 1, ALUSrcB = 01, ALU_Control = 010; IRWrite and PCWrite equal MIO_ready; all other outputs 0.
- IF (0):
  - MemRead = CPU_MIO = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, add, PCSource = 00.
  - IRWrite = PCWrite = MIO_ready.
  - Stays in IF while MIO_ready = 0; goes to ID when MIO_ready = 1.
- ID (1): ALUSrcA = 0, ALUSrcB = 11, add (branch target into ALUOut). Next state by decode:
  - lw/sw (100011/101011) -> MA.
  - R-type (000000): funct 001000 -> JR; legal funct -> RE; otherwise -> IF.
  - beq/bne (000100/000101) -> BR.
  - j (000010) -> J.
  - jal (000011) -> JAL.
  - addi/andi/ori/slti (001000/001100/001101/001010) -> IE.
  - lui (001111) -> LUI.
  - Any other opcode -> IF (executes as a nop).
- MA (2): ALUSrcA = 1, ALUSrcB = 10, ExtZero = 0, add. Goes to MR for lw, MW for sw.
- MR (3): MemRead = CPU_MIO = 1, IorD = 1. Holds until MIO_ready = 1, then -> LWB.
- LWB (4): RegWrite = 1, RegDst = 00, MemtoReg = 01. -> IF.
- MW (5): MemWrite = CPU_MIO = 1, IorD = 1. Holds until MIO_ready = 1, then -> IF.
- RE (6): ALUSrcA = 1, ALUSrcB = 00, ALU_Control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt.
  - -> RWB.
- RWB (7): RegWrite = 1, RegDst = 01, MemtoReg = 00. -> IF.
- BR (8): ALUSrcA = 1, ALUSrcB = 00, sub, PCWriteCond = 1, PCSource = 01, Branch = (opcode == 000100). -> IF.
- J (9): PCWrite = 1, PCSource = 10. -> IF.
- IE (10): ALUSrcA = 1, ALUSrcB = 10. -> IWB.
  - ExtZero = 1 for andi/ori, 0 otherwise.
  - ALU op: addi add, andi and, ori or, slti slt.
- IWB (11): RegWrite = 1, RegDst = 00, MemtoReg = 00; ALU outputs held as in IE. -> IF.
- LUI (12): RegWrite = 1, RegDst = 00, MemtoReg = 10. -> IF.
- JAL (13): RegWrite = 1, RegDst = 10, MemtoReg = 11 (PC already incremented), PCWrite = 1, PCSource = 10. -> IF.
- JR (14): ALUSrcA = 1, PCWrite = 1, PCSource = 11. -> IF.
- Cycle counts with MIO_ready held at 1:
  - lw 5.
  - sw 4, R-type 4, I-type ALU 4.
  - beq/bne 3, j 3, jal 3, jr 3, lui 3.
  - Unknown opcode 2.
- Each cycle with MIO_ready = 0 in IF, MR or MW adds one cycle. Strobes stay asserted and there is no timeout.
- state_out = current state encoding.

Test Plan:
- Release reset with MIO_ready = 0 for 3 cycles -> state_out = 0, IRWrite = PCWrite = 0, MemRead = 1; MIO_ready = 1 -> IRWrite = PCWrite = 1 for one cycle, then state_out = 1.
- lw (opcode 100011), MIO_ready = 0 for 2 cycles in MR -> states 0,1,2,3,3,3,4,0; in state 4 RegWrite = 1, RegDst = 00, MemtoReg = 01; 7 cycles total.
- R-type sub (funct 100010) -> RE shows ALU_Control = 110, then RWB shows RegWrite = 1, RegDst = 01; jal -> state 13 with RegDst = 10, MemtoReg = 11, PCWrite = 1, PCSource = 10.
- beq then bne -> state 8 with PCWriteCond = 1, PCSource = 01, Branch = 1 then 0; andi -> IE shows ExtZero = 1, ALU_Control = 000.
- Illegal opcode 111111, and R-type funct 000001 -> ID goes directly to IF, with RegWrite/MemWrite/PCWrite never asserted after IF.
- rst_n pulsed low mid-MW (state 5, MemWrite = 1) -> state_out = 0 and MemWrite = 0 immediately (asynchronous); next fetch proceeds normally.
